// File: rtl/sqrt_iter_ctrl_if.sv
// Shared magnitude comparator port of the iterative square-root controller.
// The controller is the master; the comparator (or its arbiter) is the slave.
interface sqrt_iter_ctrl_if #(
    parameter int C = 10
);
    logic         cmp_req_o;
    logic         cmp_gnt_i;
    logic [C-1:0] cmp_a_o;
    logic [C-1:0] cmp_b_o;
    logic [1:0]   cmp_res_i;

    modport master (
        output cmp_req_o,
        output cmp_a_o,
        output cmp_b_o,
        input  cmp_gnt_i,
        input  cmp_res_i
    );

    modport slave (
        input  cmp_req_o,
        input  cmp_a_o,
        input  cmp_b_o,
        output cmp_gnt_i,
        output cmp_res_i
    );
endinterface

// File: rtl/sqrt_iter_ctrl.sv
// Restoring digit-by-digit integer square root, two radicand bits per step,
// sequencing one arbitrated comparator per iteration.
module sqrt_iter_ctrl #(
    parameter int N = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [N-1:0]     radicand_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N/2-1:0]   root_o,
    output logic [N/2:0]     remainder_o,
    sqrt_iter_ctrl_if.master cmp
);
    localparam int R  = N / 2;
    localparam int C  = R + 2;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        UPD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  rad;
    logic [R:0]    rem;
    logic [R-1:0]  root;
    logic [CW-1:0] cnt;
    logic          ge;

    logic [C-1:0]  acc;
    logic [C-1:0]  trial;
    logic [R:0]    rem_nxt;
    logic [R-1:0]  root_nxt;
    logic          unused_rem_msb;

    // Mid-run remainder never exceeds 2*root < 2^R, so its MSB is
    // only ever set after the last iteration.
    assign acc            = {rem[R-1:0], rad[N-1:N-2]};
    assign trial          = {root, 2'b01};
    assign unused_rem_msb = rem[R];

    assign rem_nxt  = ge ? (acc[R:0] - trial[R:0]) : acc[R:0];
    assign root_nxt = {root[R-2:0], ge};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = CMP;
            CMP:  if (cmp.cmp_gnt_i) state_nxt = UPD;
            UPD:  state_nxt = (cnt == '0) ? DONE : CMP;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_o        = (state == CMP) || (state == UPD);
    assign done_o        = (state == DONE);
    assign cmp.cmp_req_o = (state == CMP);
    assign cmp.cmp_a_o   = (state == CMP) ? acc : '0;
    assign cmp.cmp_b_o   = (state == CMP) ? trial : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            rad         <= '0;
            rem         <= '0;
            root        <= '0;
            cnt         <= '0;
            ge          <= 1'b0;
            root_o      <= '0;
            remainder_o <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        rad  <= radicand_i;
                        rem  <= '0;
                        root <= '0;
                        cnt  <= CW'(R - 1);
                    end
                end
                CMP: begin
                    if (cmp.cmp_gnt_i) begin
                        ge <= (cmp.cmp_res_i == 2'b01) ||
                              (cmp.cmp_res_i == 2'b00);
                    end
                end
                UPD: begin
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    rad  <= {rad[N-3:0], 2'b00};
                    if (cnt == '0) begin
                        root_o      <= root_nxt;
                        remainder_o <= rem_nxt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Self-checking bench for sqrt_iter_ctrl: directed cases plus a random
// sweep with grant stalls against a plain-arithmetic square-root model.
module tb_sqrt_iter_ctrl;
    localparam int N = 16;
    localparam int R = 8;
    localparam int C = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] radicand = '0;
    logic         busy;
    logic         done;
    logic [R-1:0] root;
    logic [R:0]   rem;

    int checks = 0;
    int failures = 0;
    int stall_plan[8];
    int iter = 0;
    int stall_left = 0;
    bit noise = 1'b0;

    sqrt_iter_ctrl_if #(.C(C)) cmp();

    sqrt_iter_ctrl #(.N(N)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .radicand_i  (radicand),
        .busy_o      (busy),
        .done_o      (done),
        .root_o      (root),
        .remainder_o (rem),
        .cmp         (cmp)
    );

    always #5 clk = ~clk;

    assign cmp.cmp_res_i =
        (cmp.cmp_a_o < cmp.cmp_b_o) ? 2'b10 :
        (cmp.cmp_a_o > cmp.cmp_b_o) ? 2'b01 : 2'b00;

    // Grant driver: withholds the grant for stall_plan[i] cycles in CMP i.
    initial begin
        cmp.cmp_gnt_i = 1'b0;
        forever begin
            @(negedge clk);
            if (cmp.cmp_req_o === 1'b1) begin
                if (stall_left > 0) begin
                    cmp.cmp_gnt_i = 1'b0;
                    stall_left--;
                end else begin
                    cmp.cmp_gnt_i = 1'b1;
                    iter++;
                    stall_left = (iter < 8) ? stall_plan[iter] : 0;
                end
            end else begin
                cmp.cmp_gnt_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    function automatic void ref_sqrt(input int x, output int r, output int m);
        r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        m = x - r * r;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) stall_plan[i] = 0;
    endtask

    task automatic run_op(input logic [N-1:0] x, output int dc,
                          output int rc, output bit stab,
                          output bit bsy, output bit hold);
        logic [R-1:0] pr;
        logic [R:0]   pm;
        logic [C-1:0] pa;
        logic [C-1:0] pb;
        bit           preq;
        @(negedge clk);
        start = 1'b1;
        radicand = x;
        pr = root;
        pm = rem;
        iter = 0;
        stall_left = stall_plan[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        radicand = 16'($urandom);
        dc = -1; rc = 0; stab = 1; bsy = 1; hold = 1;
        preq = 0; pa = '0; pb = '0;
        for (int c = 1; c <= 300 && dc < 0; c++) begin
            @(negedge clk);
            if (cmp.cmp_req_o === 1'b1) begin
                rc++;
                if (preq && (cmp.cmp_a_o !== pa || cmp.cmp_b_o !== pb))
                    stab = 0;
                pa = cmp.cmp_a_o;
                pb = cmp.cmp_b_o;
            end else if (cmp.cmp_a_o !== '0 || cmp.cmp_b_o !== '0) begin
                stab = 0;
            end
            preq = (cmp.cmp_req_o === 1'b1);
            if (done === 1'b1) begin
                dc = c;
                if (busy !== 1'b0) bsy = 0;
            end else begin
                if (busy !== 1'b1) bsy = 0;
                if (root !== pr || rem !== pm) hold = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cmp.cmp_req_o} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=000",
                     {busy, done, cmp.cmp_req_o});
        end
        checks++;
        if (root !== '0 || rem !== '0) begin
            failures++;
            $display("FAIL reset_res got=%0d/%0d exp=0/0", root, rem);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [N-1:0] xs[4] = '{16'd0, 16'd65535, 16'd144, 16'd200};
        int rs[4] = '{0, 255, 12, 14};
        int ms[4] = '{0, 510, 0, 4};
        int dc, rc;
        bit stab, bsy, hold;
        clear_plan();
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], dc, rc, stab, bsy, hold);
            checks++;
            if (dc != 17) begin
                failures++;
                $display("FAIL basic_lat x=%0d got=%0d exp=17", xs[i], dc);
            end
            checks++;
            if (rc != 8) begin
                failures++;
                $display("FAIL basic_req x=%0d got=%0d exp=8", xs[i], rc);
            end
            checks++;
            if (root !== R'(rs[i]) || rem !== (R+1)'(ms[i])) begin
                failures++;
                $display("FAIL basic_res x=%0d got=%0d/%0d exp=%0d/%0d",
                         xs[i], root, rem, rs[i], ms[i]);
            end
            checks++;
            if (!(stab && bsy && hold)) begin
                failures++;
                $display("FAIL basic_flags x=%0d got=%b%b%b exp=111",
                         xs[i], stab, bsy, hold);
            end
        end
    endtask

    task automatic test_stall();
        int dc, rc;
        bit stab, bsy, hold;
        clear_plan();
        stall_plan[0] = 3;
        stall_plan[7] = 2;
        run_op(16'd1000, dc, rc, stab, bsy, hold);
        clear_plan();
        checks++;
        if (dc != 22) begin
            failures++;
            $display("FAIL stall_lat got=%0d exp=22", dc);
        end
        checks++;
        if (rc != 13) begin
            failures++;
            $display("FAIL stall_req got=%0d exp=13", rc);
        end
        checks++;
        if (root !== 8'd31 || rem !== 9'd39) begin
            failures++;
            $display("FAIL stall_res got=%0d/%0d exp=31/39", root, rem);
        end
        checks++;
        if (!(stab && bsy)) begin
            failures++;
            $display("FAIL stall_stable got=%b%b exp=11", stab, bsy);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int dcyc = -1;
        int dc, rc;
        bit stab, bsy, hold;
        clear_plan();
        @(negedge clk);
        start = 1'b1;
        radicand = 16'd9;
        iter = 0;
        stall_left = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 12);
            radicand = 16'($urandom_range(10000, 65535));
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 1 || dcyc != 17) begin
            failures++;
            $display("FAIL b2b_done got=%0d@%0d exp=1@17", ndone, dcyc);
        end
        checks++;
        if (root !== 8'd3 || rem !== 9'd0) begin
            failures++;
            $display("FAIL b2b_res got=%0d/%0d exp=3/0", root, rem);
        end
        run_op(16'd121, dc, rc, stab, bsy, hold);
        checks++;
        if (dc != 17 || root !== 8'd11 || rem !== 9'd0) begin
            failures++;
            $display("FAIL b2b_second got=%0d/%0d@%0d exp=11/0@17",
                     root, rem, dc);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int dc, rc;
        bit stab, bsy, hold;
        clear_plan();
        @(negedge clk);
        start = 1'b1;
        radicand = 16'd12345;
        iter = 0;
        stall_left = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cmp.cmp_req_o} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_ctl got=%b exp=000",
                     {busy, done, cmp.cmp_req_o});
        end
        checks++;
        if (root !== '0 || rem !== '0) begin
            failures++;
            $display("FAIL rstmid_res got=%0d/%0d exp=0/0", root, rem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL rstmid_nodone got=%0d exp=0", ndone);
        end
        run_op(16'd50, dc, rc, stab, bsy, hold);
        checks++;
        if (dc != 17 || root !== 8'd7 || rem !== 9'd1) begin
            failures++;
            $display("FAIL rstmid_after got=%0d/%0d@%0d exp=7/1@17",
                     root, rem, dc);
        end
    endtask

    task automatic test_random();
        int dc, rc, r, m, sum, x;
        bit stab, bsy, hold;
        noise = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            sum = 0;
            for (int i = 0; i < 8; i++) begin
                stall_plan[i] = ($urandom_range(0, 3) == 0) ?
                                int'($urandom_range(1, 3)) : 0;
                sum += stall_plan[i];
            end
            x = int'($urandom_range(0, 65535));
            if (n == 0) x = 65535;
            if (n == 1) x = 1;
            run_op(N'(x), dc, rc, stab, bsy, hold);
            ref_sqrt(x, r, m);
            checks++;
            if (dc != 17 + sum) begin
                failures++;
                $display("FAIL rnd_lat x=%0d got=%0d exp=%0d",
                         x, dc, 17 + sum);
            end
            checks++;
            if (root !== R'(r) || rem !== (R+1)'(m)) begin
                failures++;
                $display("FAIL rnd_res x=%0d got=%0d/%0d exp=%0d/%0d",
                         x, root, rem, r, m);
            end
            checks++;
            if (int'(root) * int'(root) + int'(rem) != x ||
                int'(rem) > 2 * int'(root)) begin
                failures++;
                $display("FAIL rnd_ident x=%0d got=%0d/%0d exp=r*r+m=x",
                         x, root, rem);
            end
            checks++;
            if (!(stab && bsy && hold)) begin
                failures++;
                $display("FAIL rnd_flags x=%0d got=%b%b%b exp=111",
                         x, stab, bsy, hold);
            end
        end
        noise = 1'b0;
        clear_plan();
    endtask

    initial begin
        clear_plan();
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sqrt_iter_ctrl.md
# sqrt_iter_ctrl

Iterative controller for the digit-by-digit (restoring, two bits per step) integer square root. It sequences one shared magnitude comparator across N/2 iterations, owns the partial-root and remainder registers, and performs the conditional subtract. Each iteration requests the comparator and waits for a grant, so the comparator can be arbitrated with other users. It sits between the square-root top level and the comparator stage.

## Interface
- N, 16, radicand width; even, ≥4. Root width R = N/2, remainder width R+1, comparator operand width C = R+2.
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request a new computation; sampled only in IDLE
- radicand_i  in  N  operand; captured on the accepted start edge
- busy_o  out  1  high from the accepted start until the cycle before done_o
- done_o  out  1  one-cycle pulse; results are valid from this cycle
- root_o  out  R  floor(sqrt(radicand)); holds until the next done_o
- remainder_o  out  R+1  radicand − root²; holds until the next done_o
- cmp_req_o  out  1  comparator request; high in CMP
- cmp_gnt_i  in  1  comparator granted this cycle; result valid this cycle
- cmp_a_o  out  C  shifted partial remainder
- cmp_b_o  out  C  trial value
- cmp_res_i  in  2  combinational compare result: 2'b10 A<B, 2'b01 A>B, 2'b00 A==B, 2'b11 illegal

## Operation
- Registers:
  - rad: N bits, shifted left 2 per iteration.
  - rem: R+1 bits.
  - root: R bits.
  - cnt: counts R−1 down to 0.
  - ge: 1 bit.
  - FSM states: IDLE, CMP, UPD, DONE.
- IDLE, start_i=1:
  - rad ← radicand_i; rem ← 0; root ← 0; cnt ← R−1.
  - Go to CMP.
- CMP, combinational operand drive:
  - cmp_a_o = {rem, rad[N−1:N−2]}, zero-extended to C bits.
  - cmp_b_o = {root, 2'b01}, zero-extended to C bits.
  - cmp_req_o = 1.
- CMP, cmp_gnt_i=0: stay in CMP. Operands and registers are unchanged.
- CMP, cmp_gnt_i=1: ge ← (cmp_res_i is 2'b01 or 2'b00). 2'b11 is treated as A<B. Go to UPD.
- UPD:
  - If ge: rem ← cmp_a_o − cmp_b_o, truncated to R+1 bits (always fits); root ← {root[R−2:0], 1}.
  - Else: rem ← cmp_a_o[R:0] (always fits); root ← {root[R−2:0], 0}.
  - rad ← rad << 2.
  - If cnt==0: go to DONE. Else cnt ← cnt−1 and go to CMP.
- DONE:
  - root_o ← root and remainder_o ← rem, loaded on the entering edge.
  - done_o = 1 for this one cycle; busy_o = 0.
  - Next state is IDLE. start_i is ignored in DONE.
- start_i in CMP/UPD/DONE is ignored. No queueing, no abort.
- All cmp_* outputs are 0 outside CMP.

## Timing
- Reset, async assert:
  - FSM → IDLE; all registers 0.
  - busy_o = 0, done_o = 0, cmp_req_o = 0, root_o = 0, remainder_o = 0.
- Reset mid-computation discards the computation with no done_o. The first start_i after deassertion is accepted normally.
- Latency without stalls: start accepted at edge 0 → done_o high in cycle N+1 (cycle 17 for N=16).
  - busy_o is high in cycles 1..N.
- Each cycle cmp_gnt_i is low in CMP adds exactly one cycle of latency.
- Throughput: one result per N+2 cycles minimum, since IDLE must be revisited.
- cmp_a_o/cmp_b_o are stable for the whole time cmp_req_o is high. The requester may hold cmp_req_o high across stalls; it never drops before a grant.
- cmp_gnt_i and cmp_res_i are ignored outside CMP.

## Test plan
- Reset then radicand 0 → done_o at cycle 17; root_o=0, remainder_o=0; cmp_req_o high in exactly 8 cycles.
- Radicand 65535 → root_o=255, remainder_o=510. Also 144 → 12/0 and 200 → 14/4.
- cmp_gnt_i held low for 3 cycles in the first CMP and 2 cycles in the last CMP, radicand 1000 → root 31, remainder 39. done_o lands at cycle 22. Operands stay stable during each stall.
- start_i pulsed in busy cycles 5 and 12 (radicand 9 captured) → a single done_o at cycle 17 with root 3, remainder 0. A second start in the cycle after done_o is accepted.
- rst_n_i asserted at cycle 8 of a run → all outputs 0 immediately with no done_o. After release, radicand 50 → 7/1 at the nominal latency.
- Random sweep of 2000 radicands with random grant stalls against a reference model. Check root² + rem = radicand, rem ≤ 2·root, and that results hold between done_o pulses.
